// File: rtl/vadd_burst_scheduler_pkg.sv
// Shared types and default sizing for the vector-adder burst scheduler.
package vadd_sched_pkg;

    localparam int C_NUM_REQ_DEF   = 4;
    localparam int C_LEN_WIDTH_DEF = 16;

    // Burst lifecycle: arbitrate, feed the adder, wait for results, signal completion.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_CMPL  = 2'd3
    } state_t;

endpackage

// File: rtl/vadd_burst_scheduler_if.sv
// Requester / adder-side signal bundle for the burst scheduler.
interface vadd_burst_scheduler_if
    import vadd_sched_pkg::*;
#(
    parameter int C_NUM_REQ   = C_NUM_REQ_DEF,
    parameter int C_LEN_WIDTH = C_LEN_WIDTH_DEF
);
    localparam int C_IDX_W = $clog2(C_NUM_REQ);

    logic [C_NUM_REQ-1:0]             req_valid;
    logic [C_NUM_REQ*C_LEN_WIDTH-1:0] req_len;
    logic [C_NUM_REQ-1:0]             req_ready;
    logic [C_NUM_REQ-1:0]             grant;
    logic [C_IDX_W-1:0]               grant_idx;
    logic                             in_en;
    logic                             in_beat;
    logic                             out_beat;
    logic [C_NUM_REQ-1:0]             done;
    logic                             err;

    // Scheduler side.
    modport slave (
        input  req_valid, req_len, in_beat, out_beat,
        output req_ready, grant, grant_idx, in_en, done, err
    );

    // Requesters plus adder handshake side.
    modport master (
        output req_valid, req_len, in_beat, out_beat,
        input  req_ready, grant, grant_idx, in_en, done, err
    );

endinterface

// File: rtl/vadd_burst_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the requester closest at or after ptr wins.
module rr_arbiter #(
    parameter int C_NUM_REQ = 4
) (
    input  logic [C_NUM_REQ-1:0]         req,
    input  logic [$clog2(C_NUM_REQ)-1:0] ptr,
    output logic [C_NUM_REQ-1:0]         grant_oh,
    output logic [$clog2(C_NUM_REQ)-1:0] grant_idx,
    output logic                         any
);
    localparam int C_IDX_W = $clog2(C_NUM_REQ);

    int w_dist;
    int w_best;

    // Pick the active request with the smallest circular distance from ptr.
    always_comb begin
        grant_idx = '0;
        w_best    = C_NUM_REQ;
        w_dist    = 0;
        for (int j = 0; j < C_NUM_REQ; j++) begin
            w_dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + C_NUM_REQ - int'(ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                grant_idx = C_IDX_W'(j);
            end
        end
    end

    // Expand the winning index to one-hot; empty when nobody asks.
    always_comb begin
        any      = |req;
        grant_oh = '0;
        for (int j = 0; j < C_NUM_REQ; j++) begin
            grant_oh[j] = any && (grant_idx == C_IDX_W'(j));
        end
    end

endmodule

// File: rtl/vadd_burst_scheduler.sv
// Time-shares one vector adder between requesters, one burst at a time,
// tracking input and output beats and flagging handshake misuse.
module vadd_burst_scheduler
    import vadd_sched_pkg::*;
#(
    parameter int C_NUM_REQ   = C_NUM_REQ_DEF,
    parameter int C_LEN_WIDTH = C_LEN_WIDTH_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    vadd_burst_scheduler_if.slave bus
);
    localparam int C_IDX_W = $clog2(C_NUM_REQ);

    state_t                 r_state;
    state_t                 w_next;
    logic [C_LEN_WIDTH-1:0] r_len_q;
    logic [C_LEN_WIDTH-1:0] r_in_cnt;
    logic [C_LEN_WIDTH-1:0] r_out_cnt;
    logic [C_LEN_WIDTH-1:0] w_in_cnt_nx;
    logic [C_LEN_WIDTH-1:0] w_out_cnt_nx;
    logic [C_LEN_WIDTH-1:0] w_win_len;
    logic [C_NUM_REQ-1:0]   r_grant;
    logic [C_NUM_REQ-1:0]   w_arb_oh;
    logic [C_IDX_W-1:0]     r_grant_idx;
    logic [C_IDX_W-1:0]     r_ptr;
    logic [C_IDX_W-1:0]     w_arb_idx;
    logic                   r_err;
    logic                   w_arb_any;
    logic                   w_pick;
    logic                   w_in_ok;
    logic                   w_out_ok;
    logic                   w_err_ev;

    rr_arbiter #(.C_NUM_REQ(C_NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (r_ptr),
        .grant_oh  (w_arb_oh),
        .grant_idx (w_arb_idx),
        .any       (w_arb_any)
    );

    // Select the winning requester's burst length.
    always_comb begin
        w_win_len = '0;
        for (int j = 0; j < C_NUM_REQ; j++) begin
            if (w_arb_idx == C_IDX_W'(j)) begin
                w_win_len = bus.req_len[j*C_LEN_WIDTH +: C_LEN_WIDTH];
            end
        end
    end

    // Qualify beats. An output beat is legal only if it does not overtake the
    // inputs, counting an input beat in the same cycle; illegal beats only
    // raise err and never touch the counters.
    always_comb begin
        w_pick       = (r_state == S_IDLE) && w_arb_any;
        w_in_ok      = (r_state == S_ISSUE) && bus.in_beat;
        w_in_cnt_nx  = r_in_cnt + C_LEN_WIDTH'(w_in_ok);
        w_out_ok     = bus.out_beat && ((r_state == S_ISSUE) || (r_state == S_DRAIN))
                       && (r_out_cnt < w_in_cnt_nx);
        w_out_cnt_nx = r_out_cnt + C_LEN_WIDTH'(w_out_ok);
        w_err_ev     = (bus.in_beat && !w_in_ok) || (bus.out_beat && !w_out_ok);
    end

    // Next-state logic for the burst lifecycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_any) w_next = (w_win_len == '0) ? S_CMPL : S_ISSUE;
            S_ISSUE: if (w_in_ok && (w_in_cnt_nx == r_len_q)) w_next = S_DRAIN;
            S_DRAIN: if (w_out_cnt_nx == r_len_q) w_next = S_CMPL;
            S_CMPL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Burst bookkeeping: capture on pick, count beats, release on completion.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_len_q     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= r_err | w_err_ev;
            if (w_pick) begin
                r_len_q     <= w_win_len;
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_grant     <= w_arb_oh;
                r_grant_idx <= w_arb_idx;
            end else begin
                r_in_cnt  <= w_in_cnt_nx;
                r_out_cnt <= w_out_cnt_nx;
                if (r_state == S_CMPL) begin
                    r_grant     <= '0;
                    r_grant_idx <= '0;
                    r_ptr       <= (r_grant_idx == C_IDX_W'(C_NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
                end
            end
        end
    end

    // req_ready is combinational so the accept lands in the pick cycle; it is
    // also gated by reset so nothing is acknowledged while reset is asserted.
    assign bus.req_ready = (w_pick && aresetn) ? w_arb_oh : '0;
    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_grant_idx;
    assign bus.in_en     = (r_state == S_ISSUE);
    assign bus.done      = (r_state == S_CMPL) ? r_grant : '0;
    assign bus.err       = r_err;

endmodule

// File: doc/vadd_burst_scheduler.md
VADD_BURST_SCHEDULER -- requirements
Module: vadd_burst_scheduler

Interface
REQ-001 The block SHALL have parameter C_NUM_REQ, default 4, number of requesters sharing one vector adder (legal range 2..16).
REQ-002 The block SHALL have parameter C_LEN_WIDTH, default 16, width of the burst length in beats.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed below as name, direction, width, meaning.
REQ-004 aclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 aresetn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  C_NUM_REQ  per-requester burst request, held until accepted.
REQ-007 req_len  input  C_NUM_REQ*C_LEN_WIDTH  packed burst lengths; requester i occupies bits [i*C_LEN_WIDTH +: C_LEN_WIDTH].
REQ-008 req_ready  output  C_NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 grant  output  C_NUM_REQ  one-hot owner of the adder; all zero when idle.
REQ-010 grant_idx  output  $clog2(C_NUM_REQ)  binary index of the owner, used as the adder input mux select.
REQ-011 in_en  output  1  enables the adder input stream (gates s_tvalid/s_tready).
REQ-012 in_beat  input  1  adder input handshake (s_tvalid & s_tready).
REQ-013 out_beat  input  1  adder output handshake (m_tvalid & m_tready).
REQ-014 done  output  C_NUM_REQ  one-cycle completion pulse to the owner.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, DRAIN and CMPL.
REQ-017 IDLE: when any req_valid is high, the block SHALL pick a winner by round-robin, starting from the index after the last owner (after reset, the search starts at index 0).
REQ-018 On a pick, the block SHALL, in the same cycle, pulse req_ready for the winner, latch its len into len_q, and clear the in_cnt and out_cnt counters.
REQ-019 On a pick, the block SHALL set grant and grant_idx, registered, in the next cycle and move to ISSUE; if len is 0 it SHALL move to CMPL instead.
REQ-020 ISSUE: in_en SHALL be 1; in_cnt SHALL increment on in_beat; on the beat where in_cnt reaches len_q, in_en SHALL drop in the next cycle and the state SHALL move to DRAIN.
REQ-021 DRAIN: in_en SHALL be 0; out_cnt SHALL increment on out_beat; when out_cnt reaches len_q, the state SHALL move to CMPL.
REQ-022 out_beat SHALL be counted in ISSUE as well; an in_beat and an out_beat in the same cycle SHALL both be counted.
REQ-023 CMPL: done[owner] SHALL pulse for exactly 1 cycle, grant SHALL clear, the round-robin pointer SHALL update, and the state SHALL return to IDLE; end-to-end latency from req_ready to done is at least len+2 cycles.
REQ-024 The block SHALL NOT hold more than one burst at a time; a requester's next burst needs a new arbitration.
REQ-025 err SHALL set on any of: in_beat while in_en=0; out_beat in IDLE or CMPL; out_cnt exceeding in_cnt. The offending beat SHALL NOT be counted.
REQ-026 Counters SHALL be C_LEN_WIDTH bits wide and SHALL NOT wrap; len = 2^C_LEN_WIDTH-1 SHALL be supported.
REQ-027 A req_valid that drops before acceptance SHALL be ignored without error.

Reset
REQ-028 When aresetn is low, the block SHALL immediately force: state=IDLE, req_ready=0, grant=0, grant_idx=0, in_en=0, done=0, err=0, counters=0, round-robin pointer=0.
REQ-029 A reset mid-burst SHALL abandon the burst, with no done pulse issued.

Structure
REQ-030 Package vadd_sched_pkg SHALL hold the state enum typedef and the default values of C_NUM_REQ and C_LEN_WIDTH.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter with inputs (req, ptr) and outputs (grant_oh, grant_idx, any).

Verification
REQ-032 Scenario: req_valid=0001, len=3, 3 in_beats then 3 out_beats -> req_ready[0] pulses once, in_en high for 3 beats, done[0] pulses once, err=0.
REQ-033 Scenario: req_valid=1111 held, all len=1 -> grants in order 0,1,2,3,0, with no requester granted twice in a row while others wait.
REQ-034 Scenario: len=0 on requester 2 -> req_ready[2] then done[2] within 2 cycles, in_en never 1.
REQ-035 Scenario: len=4 with in_beat and out_beat coincident on every cycle -> done after 4 beats plus at most 2 cycles, err=0.
REQ-036 Scenario: out_beat injected while IDLE -> err=1 and stays 1 until reset; state unaffected.
REQ-037 Scenario: aresetn low after 2 of 5 in_beats -> all outputs 0 asynchronously; the next request is granted from index 0.
